// File: rtl/wb_stage.sv
// Writeback stage: accepts one retiring instruction, formats load data, drives the register-file write port.
// Optional: define WB_COMMIT_CNT_EN to add a 64-bit retired-instruction counter output (commit_cnt).
module wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [RF_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_result,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 commit_valid,
  output logic [XLEN-1:0]      commit_pc,
`ifdef WB_COMMIT_CNT_EN
  output logic [63:0]          commit_cnt,
`endif
  output logic                 misalign
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_t;

  state_t                 state, state_n;
  logic [XLEN-1:0]        pc_q, data_q, load_fmt;
  logic [RF_ADDR_W-1:0]   rd_q;
  logic [2:0]             funct3_q;
  logic [1:0]             addr_q;
  logic                   is_load_q;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic                   accept, in_write;

  assign accept   = in_valid && (state == IDLE);
  assign in_write = (state == WRITE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (accept) state_n = in_is_load ? LOAD_WAIT : WRITE;
      LOAD_WAIT: if (mem_rvalid) state_n = WRITE;
      WRITE:     state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Lane extraction from the aligned word; halfword uses addr[1] even when misaligned.
  always_comb begin
    byte_sel = '0;
    unique case (addr_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      funct3_q  <= '0;
      addr_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q      <= in_pc;
        rd_q      <= in_rd;
        funct3_q  <= in_funct3;
        addr_q    <= in_result[1:0];
        is_load_q <= in_is_load;
        if (!in_is_load) data_q <= in_result;
      end
      if (state == LOAD_WAIT && mem_rvalid) data_q <= load_fmt;
    end
  end

`ifdef WB_COMMIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)           commit_cnt <= '0;
    else if (in_write) commit_cnt <= commit_cnt + 64'd1;
  end
`endif

  assign in_ready     = (state == IDLE);
  assign rf_wen       = in_write && (rd_q != '0);
  assign rf_waddr     = in_write ? rd_q : '0;
  assign rf_wdata     = in_write ? data_q : '0;
  assign commit_valid = in_write;
  assign commit_pc    = in_write ? pc_q : '0;
  assign misalign     = in_write && is_load_q &&
                        (((funct3_q == 3'b001 || funct3_q == 3'b101) && addr_q[0]) ||
                         ((funct3_q == 3'b010 || funct3_q == 3'b011 ||
                           funct3_q == 3'b110 || funct3_q == 3'b111) && addr_q != 2'd0));

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; checks sampled on the falling clock edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, mem_rvalid;
  logic [31:0] in_pc, in_result, mem_rdata, rf_wdata, commit_pc;
  logic [4:0]  in_rd, rf_waddr;
  logic [2:0]  in_funct3;
  logic        rf_wen, commit_valid, misalign;
`ifdef WB_COMMIT_CNT_EN
  logic [63:0] commit_cnt;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_result(in_result), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
`ifdef WB_COMMIT_CNT_EN
    .commit_cnt(commit_cnt),
`endif
    .misalign(misalign)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3);
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_result = res; in_is_load = ld; in_funct3 = f3;
    tick();
    in_valid = 1'b0; in_pc = '0; in_rd = '0; in_result = '0; in_is_load = 1'b0; in_funct3 = '0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1'b1; mem_rdata = data;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic expect_write(input string tag, input logic wen, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] pc, input logic mis);
    @(negedge clk);
    check({tag, ".wen"},      rf_wen, wen);
    check({tag, ".waddr"},    rf_waddr, wa);
    check({tag, ".wdata"},    rf_wdata, wd);
    check({tag, ".commit"},   commit_valid, 1'b1);
    check({tag, ".pc"},       commit_pc, pc);
    check({tag, ".misalign"}, misalign, mis);
    check({tag, ".ready"},    in_ready, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_result = '0;
    in_is_load = 1'b0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst.ready",  in_ready, 1'b1);
    check("rst.wen",    rf_wen, 1'b0);
    check("rst.commit", commit_valid, 1'b0);
    check("rst.wdata",  rf_wdata, 32'h0);
    check("rst.mis",    misalign, 1'b0);
`ifdef WB_COMMIT_CNT_EN
    check("rst.cnt",    commit_cnt, 64'd0);
`endif
    tick();

    // ALU op, then idle again
    issue(32'h0000_0100, 5'd5, 32'h1234_5678, 1'b0, 3'b010);
    expect_write("alu", 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100, 1'b0);
    @(negedge clk);
    check("alu.ready_back", in_ready, 1'b1);
    check("alu.wen_off",    rf_wen, 1'b0);
    check("alu.commit_off", commit_valid, 1'b0);
    tick();

    // rd = 0: commit without write
    issue(32'h0000_0104, 5'd0, 32'hFFFF_FFFF, 1'b0, 3'b000);
    expect_write("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0104, 1'b0);

    // LB lane 3, response after 3 wait cycles
    issue(32'h0000_0200, 5'd7, 32'h0000_1003, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb.wait_ready", in_ready, 1'b0);
      check("lb.wait_wen",   rf_wen, 1'b0);
      check("lb.wait_cmt",   commit_valid, 1'b0);
      tick();
    end
    respond(32'h80AA_BBCC);
    expect_write("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 32'h0000_0200, 1'b0);

    issue(32'h0000_0204, 5'd8, 32'h0000_2002, 1'b1, 3'b101);
    respond(32'h8001_0000);
    expect_write("lhu", 1'b1, 5'd8, 32'h0000_8001, 32'h0000_0204, 1'b0);

    issue(32'h0000_0208, 5'd9, 32'h0000_3001, 1'b1, 3'b001);
    respond(32'h1234_8765);
    expect_write("lh_mis", 1'b1, 5'd9, 32'hFFFF_8765, 32'h0000_0208, 1'b1);

    issue(32'h0000_020C, 5'd10, 32'h0000_4001, 1'b1, 3'b100);
    respond(32'h80AA_BBCC);
    expect_write("lbu", 1'b1, 5'd10, 32'h0000_00BB, 32'h0000_020C, 1'b0);

    issue(32'h0000_0210, 5'd11, 32'h0000_5002, 1'b1, 3'b010);
    respond(32'hDEAD_BEEF);
    expect_write("lw_mis", 1'b1, 5'd11, 32'hDEAD_BEEF, 32'h0000_0210, 1'b1);

    // Stray response while idle is ignored
    respond(32'h5555_5555);
    @(negedge clk);
    check("stray.commit", commit_valid, 1'b0);
    check("stray.ready",  in_ready, 1'b1);
    tick();

    // Reset while a load is outstanding
    issue(32'h0000_0300, 5'd12, 32'h0000_6000, 1'b1, 3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstld.ready",  in_ready, 1'b1);
    check("rstld.commit", commit_valid, 1'b0);
    tick();
    respond(32'h1111_2222);
    @(negedge clk);
    check("rstld.wen",    rf_wen, 1'b0);
    check("rstld.commit2", commit_valid, 1'b0);
    check("rstld.ready2", in_ready, 1'b1);
    tick();

`ifdef WB_COMMIT_CNT_EN
    for (int i = 0; i < 10; i++) begin
      issue(32'h400 + 32'(i * 4), (i % 4 == 0) ? 5'd0 : 5'(i), 32'(i), 1'b0, 3'b000);
      tick();
    end
    @(negedge clk);
    check("cnt.ten", commit_cnt, 64'd10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("cnt.rst", commit_cnt, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
